// File: rtl/nios_uart_mem_pkg.sv
// Shared types and constants for the Nios/UART on-chip RAM arbiter.
// Holds bus widths, the default RAM depth and error word, the port id
// type, the Avalon-MM request bundle used to mux the two masters, and
// the two-requester round-robin pick function.
package nios_uart_mem_pkg;

  localparam int ADDR_W        = 14;
  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;
  localparam int DEPTH_DEFAULT = 8750;
  localparam logic [DATA_W-1:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

  typedef logic port_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } avmm_req_t;

  // Round-robin pick for two requesters: a lone requester always wins,
  // under contention the port that did not win last time goes first.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input port_id_t last);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/nios_uart_onchip_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request per port
//   grant[1:0] : one-hot grant, combinational from req; all-zero in reset
// last_grant resets to 1 so port 0 wins the first contention, and only
// moves in cycles that actually issue a grant.
module rr_arb2
  import nios_uart_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  port_id_t last_grant;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      grant = rr_pick(req, last_grant);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/nios_uart_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM (s1) between the Nios II data
// master (port 0) and the UART boot/debug master (port 1).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   pN_address/byteenable/read/write/writedata : Avalon-MM request, port N
//   pN_waitrequest             : request not accepted this cycle
//   pN_readdata/readdatavalid  : read response, one cycle after grant
//   pN_oob_err                 : sticky out-of-range access flag
//   mem_*                      : RAM request side, mem_readdata is RAM q
// One grant per cycle, combinational from the requests. Accesses at or
// beyond DEPTH never reach the RAM: writes are dropped, reads are
// answered with ERR_WORD. Both raise the requesting port's oob flag.
module nios_uart_onchip_mem_arbiter
  import nios_uart_mem_pkg::*;
#(
  parameter int unsigned       DEPTH    = DEPTH_DEFAULT,
  parameter logic [DATA_W-1:0] ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,
  output logic              p0_oob_err,

  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,
  output logic              p1_oob_err,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  avmm_req_t         req0;
  avmm_req_t         req1;
  avmm_req_t         sel;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              grant_any;
  port_id_t          sel_port;
  logic              sel_ok;
  logic              sel_rd;

  logic [ADDR_W-1:0] addr_hold;
  logic [BE_W-1:0]   be_hold;
  logic [DATA_W-1:0] wdata_hold;

  logic              rsp_vld_p1;
  port_id_t          rsp_port_p1;
  logic              rsp_oob_p1;
  logic [1:0]        oob_err;
  logic [DATA_W-1:0] rsp_data_p1;

  // Stage 0: request capture, arbitration and RAM request mux
  always_comb begin
    req0            = '0;
    req0.address    = p0_address;
    req0.byteenable = p0_byteenable;
    req0.read       = p0_read;
    req0.write      = p0_write;
    req0.writedata  = p0_writedata;
    req1            = '0;
    req1.address    = p1_address;
    req1.byteenable = p1_byteenable;
    req1.read       = p1_read;
    req1.write      = p1_write;
    req1.writedata  = p1_writedata;
  end

  assign req = {p1_read | p1_write, p0_read | p0_write};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign grant_any = |grant;
  assign sel_port  = grant[1];
  assign sel       = sel_port ? req1 : req0;
  assign sel_ok    = in_range(sel.address);
  // Read+write together is treated as a write, so it gets no response.
  assign sel_rd    = sel.read & ~sel.write;

  assign p0_waitrequest = reset | (req[0] & ~grant[0]);
  assign p1_waitrequest = reset | (req[1] & ~grant[1]);

  // Address, byte lanes and write data park on the last granted values
  // when idle so the RAM inputs do not toggle needlessly.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold  <= '0;
      be_hold    <= '0;
      wdata_hold <= '0;
    end else if (grant_any) begin
      addr_hold  <= sel.address;
      be_hold    <= sel.byteenable;
      wdata_hold <= sel.writedata;
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (!reset) begin
      mem_address    = grant_any ? sel.address    : addr_hold;
      mem_byteenable = grant_any ? sel.byteenable : be_hold;
      mem_writedata  = grant_any ? sel.writedata  : wdata_hold;
    end
  end

  assign mem_chipselect = grant_any & sel_ok;
  assign mem_write      = mem_chipselect & sel.write;
  assign mem_clken      = ~reset;

  // Stage 1: response routing, aligned with the RAM's one-cycle q
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_p1  <= 1'b0;
      rsp_port_p1 <= 1'b0;
      rsp_oob_p1  <= 1'b0;
      oob_err     <= 2'b00;
    end else begin
      rsp_vld_p1  <= grant_any & sel_rd;
      rsp_port_p1 <= sel_port;
      rsp_oob_p1  <= ~sel_ok;
      oob_err     <= oob_err | (grant & {2{~sel_ok}});
    end
  end

  assign rsp_data_p1 = rsp_oob_p1 ? ERR_WORD : mem_readdata;

  // Gating with reset keeps a response already in flight from leaking out
  // during the reset cycle itself.
  assign p0_readdatavalid = ~reset & rsp_vld_p1 & ~rsp_port_p1;
  assign p1_readdatavalid = ~reset & rsp_vld_p1 &  rsp_port_p1;
  assign p0_readdata      = p0_readdatavalid ? rsp_data_p1 : '0;
  assign p1_readdata      = p1_readdatavalid ? rsp_data_p1 : '0;
  assign p0_oob_err       = ~reset & oob_err[0];
  assign p1_oob_err       = ~reset & oob_err[1];

endmodule

// File: tb/tb_nios_uart_onchip_mem_arbiter.sv
// Directed bench for nios_uart_onchip_mem_arbiter with a behavioural
// 1-cycle-latency byte-enabled RAM on the mem side.
module tb_nios_uart_onchip_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [13:0] p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p1_read, p0_write, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic        p0_oob_err, p1_oob_err;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  logic [31:0] ram [0:16383];
  int checks;
  int failures;
  int rsp_count;

  nios_uart_onchip_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .p0_address       (p0_address),
    .p0_byteenable    (p0_byteenable),
    .p0_read          (p0_read),
    .p0_write         (p0_write),
    .p0_writedata     (p0_writedata),
    .p0_waitrequest   (p0_waitrequest),
    .p0_readdata      (p0_readdata),
    .p0_readdatavalid (p0_readdatavalid),
    .p0_oob_err       (p0_oob_err),
    .p1_address       (p1_address),
    .p1_byteenable    (p1_byteenable),
    .p1_read          (p1_read),
    .p1_write         (p1_write),
    .p1_writedata     (p1_writedata),
    .p1_waitrequest   (p1_waitrequest),
    .p1_readdata      (p1_readdata),
    .p1_readdatavalid (p1_readdatavalid),
    .p1_oob_err       (p1_oob_err),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, registered q.
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
      end
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_address = '0; p0_byteenable = '0; p0_read = 0; p0_write = 0; p0_writedata = '0;
    p1_address = '0; p1_byteenable = '0; p1_read = 0; p1_write = 0; p1_writedata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [13:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    p0_read = rd; p0_write = wr; p0_address = a; p0_byteenable = be; p0_writedata = wd;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [13:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    p1_read = rd; p1_write = wr; p1_address = a; p1_byteenable = be; p1_writedata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p0_turn;
    checks = 0; failures = 0; rsp_count = 0;
    for (int i = 0; i < 16384; i++) ram[i] = 32'h5A00_0000 | i;
    mem_readdata = '0;
    idle_inputs();
    reset = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    drive0(1, 0, 14'h0010, 4'hF, 32'h0);
    #1;
    check_val("rst_p0_wait",   32'(p0_waitrequest),   32'd1);
    check_val("rst_p1_wait",   32'(p1_waitrequest),   32'd1);
    check_val("rst_p0_rdv",    32'(p0_readdatavalid), 32'd0);
    check_val("rst_p0_rdata",  p0_readdata,           32'd0);
    check_val("rst_p1_rdv",    32'(p1_readdatavalid), 32'd0);
    check_val("rst_p0_oob",    32'(p0_oob_err),       32'd0);
    check_val("rst_p1_oob",    32'(p1_oob_err),       32'd0);
    check_val("rst_clken",     32'(mem_clken),        32'd0);
    check_val("rst_cs",        32'(mem_chipselect),   32'd0);
    check_val("rst_mem_write", 32'(mem_write),        32'd0);
    check_val("rst_mem_addr",  32'(mem_address),      32'd0);

    next_cycle();
    reset = 1'b0;
    idle_inputs();
    #1;
    check_val("idle_p0_wait", 32'(p0_waitrequest),   32'd0);
    check_val("idle_p1_wait", 32'(p1_waitrequest),   32'd0);
    check_val("idle_clken",   32'(mem_clken),        32'd1);
    check_val("idle_no_rdv",  32'(p0_readdatavalid), 32'd0);

    // Port 0 write then read back
    next_cycle();
    drive0(0, 1, 14'h0010, 4'hF, 32'h1234_5678);
    #1;
    check_val("wr0_cs",    32'(mem_chipselect), 32'd1);
    check_val("wr0_write", 32'(mem_write),      32'd1);
    check_val("wr0_addr",  32'(mem_address),    32'h10);
    check_val("wr0_wdata", mem_writedata,       32'h1234_5678);
    check_val("wr0_wait",  32'(p0_waitrequest), 32'd0);
    next_cycle();
    drive0(1, 0, 14'h0010, 4'hF, 32'h0);
    #1;
    check_val("rd0_cs",    32'(mem_chipselect), 32'd1);
    check_val("rd0_write", 32'(mem_write),      32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check_val("rd0_rdv",       32'(p0_readdatavalid), 32'd1);
    check_val("rd0_rdata",     p0_readdata,           32'h1234_5678);
    check_val("rd0_p1_rdv",    32'(p1_readdatavalid), 32'd0);
    check_val("rd0_p1_rdata",  p1_readdata,           32'd0);
    check_val("hold_addr",     32'(mem_address),      32'h10);
    check_val("hold_cs",       32'(mem_chipselect),   32'd0);

    // Contention: both ports stream reads for 8 cycles after a fresh reset
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      next_cycle();
      if (k < 8) begin
        drive0(1, 0, 14'h0040, 4'hF, 32'h0);
        drive1(1, 0, 14'h0041, 4'hF, 32'h0);
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 8) begin
        p0_turn = ((k % 2) == 0);
        check_val($sformatf("ct_p0_wait_%0d", k), 32'(p0_waitrequest), 32'(!p0_turn));
        check_val($sformatf("ct_p1_wait_%0d", k), 32'(p1_waitrequest), 32'(p0_turn));
        check_val($sformatf("ct_addr_%0d", k), 32'(mem_address), p0_turn ? 32'h40 : 32'h41);
      end
      if (k > 0) begin
        p0_turn = (((k - 1) % 2) == 0);
        rsp_count += int'(p0_readdatavalid) + int'(p1_readdatavalid);
        check_val($sformatf("ct_p0_rdv_%0d", k), 32'(p0_readdatavalid), 32'(p0_turn));
        check_val($sformatf("ct_p1_rdv_%0d", k), 32'(p1_readdatavalid), 32'(!p0_turn));
        if (p0_turn) check_val($sformatf("ct_p0_data_%0d", k), p0_readdata, 32'h5A00_0040);
        else         check_val($sformatf("ct_p1_data_%0d", k), p1_readdata, 32'h5A00_0041);
      end
    end
    check_val("ct_rsp_count", 32'(rsp_count), 32'd8);

    // Port 1 partial-byte write
    next_cycle();
    drive1(0, 1, 14'h0100, 4'hF, 32'h1111_1111);
    next_cycle();
    drive1(0, 1, 14'h0100, 4'b0101, 32'hAABB_CCDD);
    next_cycle();
    drive1(1, 0, 14'h0100, 4'hF, 32'h0);
    next_cycle();
    idle_inputs();
    #1;
    check_val("be_p1_rdv",   32'(p1_readdatavalid), 32'd1);
    check_val("be_p1_rdata", p1_readdata,           32'h11BB_11DD);
    check_val("be_p0_rdv",   32'(p0_readdatavalid), 32'd0);

    // Range boundary on port 0
    next_cycle();
    drive0(1, 0, 14'h2200, 4'hF, 32'h0);
    next_cycle();
    drive0(1, 0, 14'h2300, 4'hF, 32'h0);
    #1;
    check_val("rng_in_rdv",   32'(p0_readdatavalid), 32'd1);
    check_val("rng_in_data",  p0_readdata,           32'h5A00_2200);
    check_val("rng_oob_cs",   32'(mem_chipselect),   32'd0);
    check_val("rng_oob_wait", 32'(p0_waitrequest),   32'd0);
    check_val("rng_oob_pre",  32'(p0_oob_err),       32'd0);
    next_cycle();
    drive0(0, 1, 14'h3FFF, 4'hF, 32'h0102_0304);
    #1;
    check_val("rng_oob_rdv",  32'(p0_readdatavalid), 32'd1);
    check_val("rng_oob_data", p0_readdata,           32'hDEAD_BEEF);
    check_val("rng_oob_flag", 32'(p0_oob_err),       32'd1);
    check_val("rng_p1_flag",  32'(p1_oob_err),       32'd0);
    check_val("rng_wr_cs",    32'(mem_chipselect),   32'd0);
    check_val("rng_wr_write", 32'(mem_write),        32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check_val("rng_wr_norsp", 32'(p0_readdatavalid), 32'd0);
    check_val("rng_ram_keep", ram[14'h3FFF],         32'h5A00_3FFF);
    check_val("rng_sticky",   32'(p0_oob_err),       32'd1);

    // Reset while a read response is pending
    next_cycle();
    drive0(1, 0, 14'h0010, 4'hF, 32'h0);
    #1;
    check_val("mr_grant_cs", 32'(mem_chipselect), 32'd1);
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    #1;
    check_val("mr_rst_rdv",   32'(p0_readdatavalid), 32'd0);
    check_val("mr_rst_rdata", p0_readdata,           32'd0);
    check_val("mr_rst_wait0", 32'(p0_waitrequest),   32'd1);
    check_val("mr_rst_wait1", 32'(p1_waitrequest),   32'd1);
    next_cycle();
    reset = 1'b0;
    #1;
    check_val("mr_post_rdv", 32'(p0_readdatavalid), 32'd0);
    check_val("mr_post_oob", 32'(p0_oob_err),       32'd0);
    next_cycle();
    drive0(1, 0, 14'h0040, 4'hF, 32'h0);
    drive1(1, 0, 14'h0041, 4'hF, 32'h0);
    #1;
    check_val("mr_first_w0", 32'(p0_waitrequest), 32'd0);
    check_val("mr_first_w1", 32'(p1_waitrequest), 32'd1);
    check_val("mr_first_a",  32'(mem_address),    32'h40);
    next_cycle();
    idle_inputs();
    #1;
    check_val("mr_first_rdv",  32'(p0_readdatavalid), 32'd1);
    check_val("mr_first_data", p0_readdata,           32'h5A00_0040);

    // Write on port 0, read of same word on port 1 the next cycle
    next_cycle();
    drive0(0, 1, 14'h0020, 4'hF, 32'hCAFE_F00D);
    next_cycle();
    idle_inputs();
    drive1(1, 0, 14'h0020, 4'hF, 32'h0);
    next_cycle();
    idle_inputs();
    #1;
    check_val("raw_p1_rdv",  32'(p1_readdatavalid), 32'd1);
    check_val("raw_p1_data", p1_readdata,           32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_uart_onchip_mem_arbiter.md
# nios_uart_onchip_mem_arbiter

Two-port Avalon-MM arbiter that shares the single-port on-chip program/data RAM (32-bit words, 14-bit word address, one-cycle read latency) between two masters: port 0 (Nios II data master) and port 1 (UART boot loader / debug master). It grants one transfer per clock, alternating fairly under contention. It routes read data back with `readdatavalid` and blocks accesses past the physical depth. It sits between the interconnect and the RAM's s1 port.

## Interface
- `DEPTH`, 8750: physical RAM depth in words. Addresses >= DEPTH are out of range.
- `ERR_WORD`, 32'hDEAD_BEEF: read data returned for out-of-range reads.
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `p0_address`, `p1_address` in 14: word address.
- `p0_byteenable`, `p1_byteenable` in 4: byte lanes.
- `p0_read`, `p1_read` in 1: read request.
- `p0_write`, `p1_write` in 1: write request. Read and write together is illegal and is treated as a write.
- `p0_writedata`, `p1_writedata` in 32: write data.
- `p0_waitrequest`, `p1_waitrequest` out 1: request not accepted this cycle. The master must hold its request.
- `p0_readdata`, `p1_readdata` out 32: read data, qualified by readdatavalid.
- `p0_readdatavalid`, `p1_readdatavalid` out 1: read response strobe.
- `p0_oob_err`, `p1_oob_err` out 1: sticky flag, set by any out-of-range access from that port.
- `mem_address` out 14, `mem_byteenable` out 4, `mem_chipselect` out 1, `mem_write` out 1, `mem_writedata` out 32: RAM request side.
- `mem_clken` out 1: RAM clock enable. Constant 1 outside reset, 0 during reset.
- `mem_readdata` in 32: RAM q, valid one cycle after the address is presented.

## Operation
- **Request:** `req_i = pi_read | pi_write`.
- **Grant:** combinational, at most one grant per cycle.
  - Only one port requests: that port is granted.
  - Both ports request: the port not in `last_grant` is granted.
- **`last_grant`:** register, reset value 1, so port 0 wins the first contention. Updates only in cycles with a grant.
- **waitrequest:** `pi_waitrequest = reset | (req_i & ~grant_i)`. With no request it is 0, except during reset.
- **Mem side:** the mem outputs mux the granted port's signals.
  - `mem_chipselect = grant_any & in_range`.
  - `mem_write = chipselect & granted write`.
  - With no grant, address, byteenable and writedata hold their last values; chipselect and write are 0.
- **Range check:** `in_range = address < DEPTH`, an unsigned 14-bit compare. Addresses 8750..16383 are out of range.
  - Out-of-range write: dropped; sets `pi_oob_err`.
  - Out-of-range read: accepted and answered with ERR_WORD; sets `pi_oob_err`.
- **Response pipeline:** one stage. Registers `rsp_valid` (granted read), `rsp_port` and `rsp_oob`, all reset 0.
  - The next cycle, `p[rsp_port]_readdatavalid = 1`.
  - `readdata` is `mem_readdata` when `rsp_oob = 0`, otherwise ERR_WORD.
- **Non-target port:** readdatavalid 0, readdata 0.
- **Writes:** no response; complete in the grant cycle.
- **Back-to-back:** full throughput. A new grant can issue every cycle, including a read issued while the previous read's response is being returned.
- **Reset mid-operation:**
  - The pending response is discarded, so no readdatavalid appears in the cycle after reset deasserts.
  - `last_grant` returns to 1 and the oob flags clear.
  - No mem access issues while reset = 1.
- **Reset values of outputs:**
  - waitrequest: 1.
  - readdatavalid, readdata, oob_err: 0.
  - `mem_*` registers/outputs: 0.
  - `mem_clken`: 0.

## Timing
- Request granted in cycle N → RAM address in cycle N → readdatavalid and readdata in cycle N+1. Read latency is fixed at 1.
- A write granted in cycle N is committed at the end of cycle N. A read of the same address granted in cycle N+1 returns the new data.
- Contention:
  - Loser waits exactly one cycle when both ports stream.
  - Grants alternate 0,1,0,1…; no port waits more than 1 cycle.
- The oob flag is visible in cycle N+1 after the offending grant in cycle N.
- The grant and waitrequest path is combinational from requests. This is the critical path: a 14-bit compare plus a 2:1 mux.

## Structure
- Package `nios_uart_mem_pkg`:
  - Constants `ADDR_W = 14`, `DATA_W = 32`, `BE_W = 4`, `DEPTH_DEFAULT = 8750`, `ERR_WORD_DEFAULT`.
  - Typedef `port_id_t` (1 bit).
  - Struct `avmm_req_t` (address, byteenable, read, write, writedata).
- Sub-module `rr_arb2`: a 2-requester round-robin with the `last_grant` register. Inputs `req[1:0]` and `reset`; output one-hot `grant[1:0]`.
- The top level holds the range check, the request mux, the response register and the oob flags.

## Test plan
- Port 0 writes 0x12345678 to 0x0010 (byteenable 4'hF), then reads 0x0010 → `p0_readdatavalid` one cycle after the grant, readdata 0x12345678, `p1_*` idle.
- Both ports read continuously, 8 cycles → grants alternate 0,1,0,…, starting with port 0. Each waitrequest high every other cycle. 8 responses total, each routed to the correct port.
- Port 1 writes 0xAABBCCDD with byteenable 4'b0101 over 0x11111111 at 0x0100, then reads → 0x11BB11DD.
- Port 0 reads 0x2200 (8704, in range) and 0x2300 (8960, out of range) → first returns RAM data. Second returns 0xDEADBEEF with `mem_chipselect` 0 and sets `p0_oob_err`. A write to 0x3FFF leaves RAM unchanged.
- Reset asserted in the cycle a read is granted → no readdatavalid afterwards. oob flags 0. waitrequest 1 during reset. First contention after reset goes to port 0.
- Port 0 writes 0xCAFEF00D to 0x0020 in cycle N; port 1 reads 0x0020 in cycle N+1 → port 1 receives 0xCAFEF00D.
